udp_rx_pixel_unpack: RTL
========================

Name: udp_rx_pixel_unpack

Overview:
- Consumer on the receive side of the UDP stack. Reads one received UDP payload out of the MAC receive RAM, validates a 4-byte video header, and unpacks RGB888 bytes into 24-bit pixels.
- Outputs go to the Ethernet-to-HDMI path (eth_hdmi_data / eth_vs / eth_valid).
- Lives in the gmii_rx_clk domain beside mac_top.

Parameters:
- MAGIC, 8'hA5, required value of payload byte 0.
- MAX_PAYLOAD, 1472, largest accepted payload in bytes (UDP length minus 8).

Ports:
- gmii_rx_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- udp_rec_data_valid  in  1  one-cycle pulse: a complete UDP packet sits in the receive RAM.
- udp_rec_data_length  in  16  UDP length field (header + payload); stable from the pulse until pkt_done.
- udp_rec_ram_read_addr  out  11  receive RAM byte address, registered.
- udp_rec_ram_rdata  in  8  RAM read data, valid one cycle after the address.
- eth_hdmi_data  out  24  pixel {R,G,B}; R is the earliest byte.
- eth_valid  out  1  one-cycle strobe per pixel.
- eth_vs  out  1  one-cycle frame-start strobe.
- line_idx  out  16  line index from the header, held until the next good header.
- busy  out  1  high from packet accept to pkt_done.
- pkt_done  out  1  one-cycle pulse when a packet is finished or aborted.
- frame_err  out  1  one-cycle pulse when a packet is rejected.
- pkt_dropped  out  1  one-cycle pulse when udp_rec_data_valid arrives while busy.

Behaviour:
- Reset values: all outputs 0. State is IDLE.
- Payload length: P = udp_rec_data_length - 8, computed in 16 bits and latched on accept.
- Payload layout:
  - byte0 = MAGIC.
  - byte1 = flags; bit0 = frame start; other bits ignored.
  - byte2..3 = line index, big-endian.
  - byte4 onward = R,G,B triplets.
- States: IDLE, READ, DONE.
- IDLE, on udp_rec_data_valid (pulse at cycle T):
  - If udp_rec_data_length < 12, or P > MAX_PAYLOAD: frame_err and pkt_done both pulse at T+1; stay IDLE; no RAM read.
  - Otherwise: addr <= 0, busy <= 1, go to READ.
- READ addressing: address k is presented in cycle T+1+k, for k = 0..P-1. The address then holds at P-1. Byte k is sampled in cycle T+2+k. A byte-index counter tracks the 1-cycle RAM latency.
- Header check: done on byte3 (cycle T+5).
  - Magic mismatch: frame_err pulses at T+6; reading stops; go to DONE. No eth_vs, no pixels.
  - Match: line_idx is updated at T+6. If flag bit0 = 1, eth_vs pulses at T+6.
- Pixel assembly: byte 4+3n is R, 5+3n is G, 6+3n is B. When B is sampled (cycle T+8+3n), eth_hdmi_data is loaded and eth_valid pulses at T+9+3n. Maximum rate is one pixel per 3 cycles.
- Trailing bytes: the last (P-4) mod 3 bytes are read and discarded. This is not an error.
- P = 4: header only. eth_vs may pulse; no pixels; normal done.
- DONE entry: one cycle after the last sampled byte. pkt_done pulses for 1 cycle; busy goes 0 in the same cycle; addr returns to 0; next state is IDLE.
- Back-to-back packets: the next udp_rec_data_valid is accepted only in IDLE.
- udp_rec_data_valid while busy (READ or DONE): pkt_dropped pulses on the next cycle. The current packet is unaffected.
- Simultaneous pulse and DONE: the pulse is dropped (pkt_dropped), not queued.
- Reset mid-packet: all outputs clear immediately. The partial packet is discarded with no pkt_done.
- Width: address fits 11 bits (P ≤ 1472 < 2048). There is no address wrap-around.

Test Plan:
- Good packet: len=8+4+6, bytes A5,01,00,07,10,20,30,40,50,60 -> eth_vs at T+6; line_idx=7; eth_valid at T+9 with 102030 and at T+12 with 405060; pkt_done at T+12; addr sequence 0..9.
- No frame start with 2 trailing bytes: len=8+4+5, flags=00, pixel AABBCC, then 2 extra bytes -> no eth_vs; one pixel AABBCC; no frame_err; pkt_done after byte 8.
- Bad magic: byte0=5A -> frame_err at T+6; no eth_vs/eth_valid; pkt_done; line_idx keeps its previous value.
- Length checks: len=11 -> frame_err and pkt_done at T+1, no RAM address change. len=8+1473 -> same. len=8+1472 full-size -> 489 pixels and 1 discarded byte, addr reaches 1471.
- Busy drop: second udp_rec_data_valid during READ and one in the DONE cycle -> pkt_dropped each time; the first packet's output is unchanged.
- Reset mid-packet: rst_n low during pixel 2 -> outputs 0 at once. A new packet after release decodes correctly from addr 0.

Source files
------------

// File: rtl/udp_rx_pixel_unpack.sv
// Reads one UDP payload from the MAC receive RAM, checks the 4-byte video header
// and unpacks RGB888 bytes into 24-bit pixels for the Ethernet-to-HDMI path.
module udp_rx_pixel_unpack #(
    parameter logic [7:0]  MAGIC       = 8'hA5,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        udp_rec_data_valid,
    input  logic [15:0] udp_rec_data_length,
    output logic [10:0] udp_rec_ram_read_addr,
    input  logic [7:0]  udp_rec_ram_rdata,
    output logic [23:0] eth_hdmi_data,
    output logic        eth_valid,
    output logic        eth_vs,
    output logic [15:0] line_idx,
    output logic        busy,
    output logic        pkt_done,
    output logic        frame_err,
    output logic        pkt_dropped
);

    localparam logic [15:0] MAX_P16 = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t      r_state, w_state_d;
    logic [10:0] r_addr;
    logic [10:0] r_plast;
    logic [10:0] r_idx;
    logic        r_dv;
    logic        r_magic_ok;
    logic        r_flag;
    logic [7:0]  r_line_hi;
    logic [15:0] r_line_idx;
    logic [1:0]  r_ph;
    logic [7:0]  r_red;
    logic [7:0]  r_grn;
    logic [23:0] r_pix;
    logic        r_valid;
    logic        r_vs;
    logic        r_busy;
    logic        r_pkt_done;
    logic        r_frame_err;
    logic        r_dropped;

    logic [15:0] w_payload;
    logic        w_len_bad;
    logic        w_abort;
    logic        w_last;

    assign w_payload = udp_rec_data_length - 16'd8;
    assign w_len_bad = (udp_rec_data_length < 16'd12) || (w_payload > MAX_P16);
    assign w_abort   = r_dv && (r_idx == 11'd3) && !r_magic_ok;
    assign w_last    = r_dv && (r_idx == r_plast);

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (udp_rec_data_valid && !w_len_bad) w_state_d = READ;
            READ:    if (w_abort || w_last) w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_plast     <= '0;
            r_idx       <= '0;
            r_dv        <= 1'b0;
            r_magic_ok  <= 1'b0;
            r_flag      <= 1'b0;
            r_line_hi   <= '0;
            r_line_idx  <= '0;
            r_ph        <= '0;
            r_red       <= '0;
            r_grn       <= '0;
            r_pix       <= '0;
            r_valid     <= 1'b0;
            r_vs        <= 1'b0;
            r_busy      <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_frame_err <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_vs        <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_frame_err <= 1'b0;
            r_dropped   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (udp_rec_data_valid) begin
                        if (w_len_bad) begin
                            r_frame_err <= 1'b1;
                            r_pkt_done  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_addr  <= '0;
                            r_plast <= w_payload[10:0] - 11'd1;
                            r_idx   <= '0;
                            r_dv    <= 1'b0;
                            r_ph    <= '0;
                        end
                    end
                end
                READ: begin
                    if (udp_rec_data_valid) r_dropped <= 1'b1;
                    if (r_addr != r_plast) r_addr <= r_addr + 11'd1;
                    // rdata lags the address by one cycle; r_dv marks the first valid byte
                    r_dv <= 1'b1;
                    if (r_dv) begin
                        r_idx <= r_idx + 11'd1;
                        if (r_idx == 11'd0) begin
                            r_magic_ok <= (udp_rec_ram_rdata == MAGIC);
                        end else if (r_idx == 11'd1) begin
                            r_flag <= udp_rec_ram_rdata[0];
                        end else if (r_idx == 11'd2) begin
                            r_line_hi <= udp_rec_ram_rdata;
                        end else if (r_idx == 11'd3) begin
                            if (r_magic_ok) begin
                                r_line_idx <= {r_line_hi, udp_rec_ram_rdata};
                                r_vs       <= r_flag;
                            end
                        end else begin
                            case (r_ph)
                                2'd0: begin
                                    r_red <= udp_rec_ram_rdata;
                                    r_ph  <= 2'd1;
                                end
                                2'd1: begin
                                    r_grn <= udp_rec_ram_rdata;
                                    r_ph  <= 2'd2;
                                end
                                default: begin
                                    r_pix   <= {r_red, r_grn, udp_rec_ram_rdata};
                                    r_valid <= 1'b1;
                                    r_ph    <= 2'd0;
                                end
                            endcase
                        end
                    end
                    if (w_abort || w_last) begin
                        r_pkt_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_addr     <= '0;
                        r_dv       <= 1'b0;
                        if (w_abort) r_frame_err <= 1'b1;
                    end
                end
                DONE: begin
                    // a pulse here is dropped, never queued
                    if (udp_rec_data_valid) r_dropped <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign udp_rec_ram_read_addr = r_addr;
    assign eth_hdmi_data         = r_pix;
    assign eth_valid             = r_valid;
    assign eth_vs                = r_vs;
    assign line_idx              = r_line_idx;
    assign busy                  = r_busy;
    assign pkt_done              = r_pkt_done;
    assign frame_err             = r_frame_err;
    assign pkt_dropped           = r_dropped;

endmodule
